alu_cmd_sequencer: RTL and testbench
====================================

# alu_cmd_sequencer

Command front-end for the 16-bit ALU. It accepts operation commands over a valid/ready handshake and buffers them in a small FIFO. It issues each command to the ALU's `A`/`B`/`ALU_FUN` inputs, then captures the registered `ALU_OUT` and flags once the ALU latency has elapsed. Each result is returned in order with its tag over a second valid/ready handshake. Divide-by-zero commands are trapped locally and never reach the ALU.

## Interface
- `DEPTH`, 4: command FIFO entries, power of 2, ≥2.
- `TAG_W`, 4: width of the caller tag carried from command to response.
- `clk`  in  1  single clock, all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept; equals `!full`; forced 0 while `rst_n`=0.
- `cmd_a`, `cmd_b`  in  16 each  operands.
- `cmd_fun`  in  4  ALU opcode (0000 add … 1110 shl, 1111 nop).
- `cmd_tag`  in  TAG_W  caller tag.
- `A`, `B`  out  16 each  registered operands to the ALU.
- `ALU_FUN`  out  4  registered opcode to the ALU.
- `ALU_OUT`  in  16  ALU result, registered inside the ALU.
- `Carry_flag`, `Arith_flag`, `Logic_flag`, `CMP_flag`, `Shift_flag`  in  1 each  ALU flags.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts.
- `rsp_data`  out  16  captured result.
- `rsp_flags`  out  5  bit map: [0] Carry, [1] Arith, [2] Logic, [3] CMP, [4] Shift.
- `rsp_tag`  out  TAG_W  tag of the command.
- `rsp_err`  out  1  divide-by-zero trap.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- **FIFO push:** on `cmd_valid && cmd_ready`. No push when full, even if a pop happens the same cycle.
- **FSM states:** IDLE, ISSUE, CAPTURE, RESP.
- **Pop rule:** a pop occurs in IDLE when the FIFO is non-empty, or in RESP on a response handshake when the FIFO is non-empty. On a pop:
  - Normal command: load `A`, `B`, `ALU_FUN` and an internal tag register, then go to ISSUE.
  - Trap (`fun`=0011 and `b`=0): set `rsp_data`=16'hFFFF, `rsp_flags`=0, `rsp_err`=1 and the tag, then go to RESP. `ALU_FUN` stays 1111.
- **ISSUE → CAPTURE:** unconditional. The ALU samples the operands on this edge. `ALU_FUN` returns to 1111 on the same edge.
- **CAPTURE → RESP:** unconditional. `rsp_data` ← `ALU_OUT`, `rsp_flags` ← the five flags, `rsp_err` ← 0.
- **RESP:** `rsp_valid`=1. `rsp_data`, `rsp_flags`, `rsp_tag` and `rsp_err` stay stable until the handshake. On the handshake, pop and go to ISSUE/RESP if the FIFO is non-empty, otherwise go to IDLE.
- **Ordering:** responses are returned strictly in command order.
- **Arithmetic:** no result processing; `rsp_data` is the raw `ALU_OUT`.
- **Pointer wrap:** pointers wrap modulo DEPTH; `level` distinguishes full from empty.
- **Reset values:** state IDLE, FIFO empty, `level`=0, `A`=`B`=0, `ALU_FUN`=1111, `rsp_valid`=0, `rsp_data`=0, `rsp_flags`=0, `rsp_tag`=0, `rsp_err`=0.
- **Reset mid-operation:** the in-flight command and all queued commands are discarded; no response is ever produced for them.

## Timing
- Command accepted at edge e0: pop at e1, ALU samples at e2, capture at e3. `rsp_valid` is high from after e3.
- Trapped command: `rsp_valid` is high from after the pop edge.
- Sustained throughput with `rsp_ready`=1: one ALU result per 3 cycles. IDLE is skipped when the queue is non-empty.
- `cmd_ready` is combinational from `level` and `rst_n` only; no combinational path from `rsp_ready`.
- The ALU is assumed to register its result on `clk` with exactly 1-cycle latency. This timing is required, not optional.

## Structure
- **Package `alu_seq_pkg`:**
  - Opcode constants OP_ADD … OP_NOP (OP_DIV=0011, OP_NOP=1111).
  - FSM state encoding.
  - Flag bit indices FLG_CARRY … FLG_SHIFT.
  - DIV0_RESULT=16'hFFFF.
- **Sub-module `alu_cmd_fifo`:** synchronous FIFO parameterised by DEPTH and entry width (36+TAG_W). Provides push, pop, head, full, empty and level.
- The FSM and the issue/capture registers live in the top module.

## Test plan
- **Single ADD:** `A`=0x0015, `B`=0x0025, fun 0000, tag 3, `rsp_ready`=1. Expect `rsp_valid` 3 edges after acceptance, `rsp_data`=0x003A, `rsp_flags`[1]=1, `rsp_tag`=3, `rsp_err`=0.
- **Fill:** six commands with `rsp_ready`=0. Expect the first popped, `level` reaching 4, `cmd_ready` low. Then `rsp_ready`=1: expect all six responses in order with matching tags, and successive `rsp_valid` pulses 3 cycles apart.
- **Divide by zero:** fun 0011, a=0x0010, b=0. Expect `rsp_data`=0xFFFF, `rsp_err`=1, `rsp_flags`=0, and `ALU_FUN` constant 1111 throughout. Follow with a=0x0010, b=0x0004: expect `rsp_data`=0x0004, `rsp_err`=0.
- **Backpressure:** hold `rsp_ready` low 5 cycles during RESP. Expect `rsp_data`, flags and tag unchanged and `ALU_FUN`=1111. On release, expect the next command driven on `A`/`B`/`ALU_FUN` on the handshake edge.
- **Compare:** a=0x0100, b=0x00FF, fun 1011. Expect `rsp_data` equal to the `ALU_OUT` sampled at the capture edge and `rsp_flags`[3]=1, others 0.
- **Reset mid-op:** assert `rst_n`=0 for 1 cycle while in CAPTURE with 2 commands queued. After that edge expect `rsp_valid`=0, `level`=0, `ALU_FUN`=1111. After release, expect no response for 10 cycles.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM encoding and flag layout for the ALU command sequencer.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_MUL   = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_AND   = 4'b0100;
    localparam logic [3:0] OP_OR    = 4'b0101;
    localparam logic [3:0] OP_NAND  = 4'b0110;
    localparam logic [3:0] OP_NOR   = 4'b0111;
    localparam logic [3:0] OP_XOR   = 4'b1000;
    localparam logic [3:0] OP_XNOR  = 4'b1001;
    localparam logic [3:0] OP_CMPEQ = 4'b1010;
    localparam logic [3:0] OP_CMPGT = 4'b1011;
    localparam logic [3:0] OP_CMPLT = 4'b1100;
    localparam logic [3:0] OP_SHR   = 4'b1101;
    localparam logic [3:0] OP_SHL   = 4'b1110;
    localparam logic [3:0] OP_NOP   = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_RESP
    } seq_state_t;

    localparam int unsigned FLG_CARRY = 0;
    localparam int unsigned FLG_ARITH = 1;
    localparam int unsigned FLG_LOGIC = 2;
    localparam int unsigned FLG_CMP   = 3;
    localparam int unsigned FLG_SHIFT = 4;

    localparam logic [15:0] DIV0_RESULT = 16'hFFFF;

    function automatic logic is_div0(input logic [3:0] fun, input logic [15:0] b);
        return (fun == OP_DIV) && (b == '0);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; level counter separates full from empty.
module alu_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 40
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_level == FULL_LVL);
    assign empty  = (r_level == '0);
    assign level  = r_level;
    assign head   = r_mem[r_rptr];
    // A full FIFO refuses the push even when a pop frees a slot this cycle.
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= din;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, issues them to a 1-cycle registered ALU and returns
// tagged results in order; divide-by-zero is answered locally.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [15:0]              cmd_a,
    input  logic [15:0]              cmd_b,
    input  logic [3:0]               cmd_fun,
    input  logic [TAG_W-1:0]         cmd_tag,
    output logic [15:0]              A,
    output logic [15:0]              B,
    output logic [3:0]               ALU_FUN,
    input  logic [15:0]              ALU_OUT,
    input  logic                     Carry_flag,
    input  logic                     Arith_flag,
    input  logic                     Logic_flag,
    input  logic                     CMP_flag,
    input  logic                     Shift_flag,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [15:0]              rsp_data,
    output logic [4:0]               rsp_flags,
    output logic [TAG_W-1:0]         rsp_tag,
    output logic                     rsp_err,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned EW = 36 + TAG_W;

    seq_state_t         r_state;
    seq_state_t         w_next_state;
    logic [TAG_W-1:0]   r_tag;
    logic [EW-1:0]      w_din;
    logic [EW-1:0]      w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_trap;
    logic [4:0]         w_flags;
    logic [15:0]        w_head_a;
    logic [15:0]        w_head_b;
    logic [3:0]         w_head_fun;
    logic [TAG_W-1:0]   w_head_tag;

    assign cmd_ready = rst_n && !w_full;
    assign w_din     = {cmd_tag, cmd_fun, cmd_b, cmd_a};
    assign {w_head_tag, w_head_fun, w_head_b, w_head_a} = w_head;
    assign w_trap    = is_div0(w_head_fun, w_head_b);

    always_comb begin
        w_flags            = '0;
        w_flags[FLG_CARRY] = Carry_flag;
        w_flags[FLG_ARITH] = Arith_flag;
        w_flags[FLG_LOGIC] = Logic_flag;
        w_flags[FLG_CMP]   = CMP_flag;
        w_flags[FLG_SHIFT] = Shift_flag;
    end

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid && cmd_ready),
        .pop   (w_pop),
        .din   (w_din),
        .head  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (level)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (w_pop) w_next_state = w_trap ? ST_RESP : ST_ISSUE;
            ST_ISSUE:   w_next_state = ST_CAPTURE;
            ST_CAPTURE: w_next_state = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    if (!w_pop)      w_next_state = ST_IDLE;
                    else if (w_trap) w_next_state = ST_RESP;
                    else             w_next_state = ST_ISSUE;
                end
            end
            default:    w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_pop     = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            ST_IDLE: w_pop = !w_empty;
            ST_RESP: begin
                rsp_valid = 1'b1;
                w_pop     = rsp_ready && !w_empty;
            end
            default: ;
        endcase
    end

    // Pop, ISSUE and CAPTURE are mutually exclusive, so no field has two writers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            A         <= '0;
            B         <= '0;
            ALU_FUN   <= OP_NOP;
            r_tag     <= '0;
            rsp_data  <= '0;
            rsp_flags <= '0;
            rsp_tag   <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (r_state == ST_ISSUE) ALU_FUN <= OP_NOP;
            if (w_pop && !w_trap) begin
                A       <= w_head_a;
                B       <= w_head_b;
                ALU_FUN <= w_head_fun;
                r_tag   <= w_head_tag;
            end
            if (w_pop && w_trap) begin
                rsp_data  <= DIV0_RESULT;
                rsp_flags <= '0;
                rsp_err   <= 1'b1;
                rsp_tag   <= w_head_tag;
            end
            if (r_state == ST_CAPTURE) begin
                rsp_data  <= ALU_OUT;
                rsp_flags <= w_flags;
                rsp_err   <= 1'b0;
                rsp_tag   <= r_tag;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench with a registered ALU model and an in-order response scoreboard.
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 4;

    typedef struct {
        logic [15:0]      data;
        logic [4:0]       flags;
        logic [TAG_W-1:0] tag;
        logic             err;
    } rsp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [15:0]      cmd_a, cmd_b;
    logic [3:0]       cmd_fun;
    logic [TAG_W-1:0] cmd_tag;
    logic [15:0]      A, B;
    logic [3:0]       ALU_FUN;
    logic [15:0]      ALU_OUT = '0;
    logic [4:0]       alu_flg = '0;
    logic             rsp_valid, rsp_ready;
    logic [15:0]      rsp_data;
    logic [4:0]       rsp_flags;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;
    logic [$clog2(DEPTH):0] level;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_hs = -1000;
    int   gap_from = 0;
    bit   gap_en = 0;
    bit   fun_watch = 0;
    bit   fun_bad = 0;
    rsp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_cmd_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_fun(cmd_fun), .cmd_tag(cmd_tag),
        .A(A), .B(B), .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT),
        .Carry_flag(alu_flg[0]), .Arith_flag(alu_flg[1]), .Logic_flag(alu_flg[2]),
        .CMP_flag(alu_flg[3]), .Shift_flag(alu_flg[4]),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
        .rsp_err(rsp_err), .level(level)
    );

    // Reference ALU: result and flags registered with one-cycle latency.
    always @(posedge clk) begin
        logic [16:0] s;
        s = {1'b0, A} + {1'b0, B};
        case (ALU_FUN)
            OP_ADD:   begin ALU_OUT <= s[15:0];  alu_flg <= {4'b0001, s[16]}; end
            OP_SUB:   begin ALU_OUT <= A - B;    alu_flg <= 5'b00010; end
            OP_MUL:   begin ALU_OUT <= A * B;    alu_flg <= 5'b00010; end
            OP_DIV:   begin ALU_OUT <= (B != 0) ? A / B : 16'h0; alu_flg <= 5'b00010; end
            OP_AND:   begin ALU_OUT <= A & B;    alu_flg <= 5'b00100; end
            OP_OR:    begin ALU_OUT <= A | B;    alu_flg <= 5'b00100; end
            OP_NAND:  begin ALU_OUT <= ~(A & B); alu_flg <= 5'b00100; end
            OP_NOR:   begin ALU_OUT <= ~(A | B); alu_flg <= 5'b00100; end
            OP_XOR:   begin ALU_OUT <= A ^ B;    alu_flg <= 5'b00100; end
            OP_XNOR:  begin ALU_OUT <= ~(A ^ B); alu_flg <= 5'b00100; end
            OP_CMPEQ: begin ALU_OUT <= (A == B) ? 16'd1 : 16'd0; alu_flg <= 5'b01000; end
            OP_CMPGT: begin ALU_OUT <= (A > B)  ? 16'd2 : 16'd0; alu_flg <= 5'b01000; end
            OP_CMPLT: begin ALU_OUT <= (A < B)  ? 16'd3 : 16'd0; alu_flg <= 5'b01000; end
            OP_SHR:   begin ALU_OUT <= A >> 1;   alu_flg <= 5'b10000; end
            OP_SHL:   begin ALU_OUT <= A << 1;   alu_flg <= 5'b10000; end
            default:  begin ALU_OUT <= 16'h0;    alu_flg <= 5'b00000; end
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (fun_watch && ALU_FUN !== OP_NOP) fun_bad = 1;
        if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_rsp: got tag %0d data 0x%0h, expected no response", rsp_tag, rsp_data);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                chk($sformatf("rsp_data[tag%0d]", e.tag),  rsp_data,  e.data);
                chk($sformatf("rsp_flags[tag%0d]", e.tag), rsp_flags, e.flags);
                chk($sformatf("rsp_tag[tag%0d]", e.tag),   rsp_tag,   e.tag);
                chk($sformatf("rsp_err[tag%0d]", e.tag),   rsp_err,   e.err);
            end
            if (gap_en && last_hs >= gap_from) chk("rsp_gap", cyc - last_hs, 3);
            last_hs = cyc;
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] fun,
                        input logic [TAG_W-1:0] tag, input logic [15:0] ed,
                        input logic [4:0] ef, input logic ee);
        int n;
        rsp_t e;
        cmd_a = a; cmd_b = b; cmd_fun = fun; cmd_tag = tag; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 200) begin @(posedge clk); #1; n++; end
        if (!cmd_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: got cmd_ready 0 for tag %0d, expected 1", tag);
        end else begin
            e.data = ed; e.flags = ef; e.tag = tag; e.err = ee;
            sb.push_back(e);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || rsp_valid) && n < 100) begin @(posedge clk); #1; n++; end
        chk("drain_pending", sb.size(), 0);
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_fun = OP_NOP; cmd_tag = '0;
        repeat (3) @(posedge clk); #1;
        chk("rst_A", A, 0);
        chk("rst_B", B, 0);
        chk("rst_fun", ALU_FUN, OP_NOP);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_data", rsp_data, 0);
        chk("rst_flags", rsp_flags, 0);
        chk("rst_tag", rsp_tag, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_level", level, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("cmd_ready_after_rst", cmd_ready, 1);

        rsp_ready = 1'b1;
        send(16'h0015, 16'h0025, OP_ADD, 4'd3, 16'h003A, 5'b00010, 1'b0);
        repeat (2) @(posedge clk); #1;
        chk("add_valid_e2", rsp_valid, 0);
        @(posedge clk); #1;
        chk("add_valid_e3", rsp_valid, 1);
        wait_drain();

        rsp_ready = 1'b0;
        send(16'hFFFF, 16'h0002, OP_ADD, 4'd1, 16'h0001, 5'b00011, 1'b0);
        send(16'h0050, 16'h0020, OP_SUB, 4'd2, 16'h0030, 5'b00010, 1'b0);
        send(16'h0F0F, 16'h00FF, OP_AND, 4'd3, 16'h000F, 5'b00100, 1'b0);
        send(16'h0001, 16'h0000, OP_SHL, 4'd4, 16'h0002, 5'b10000, 1'b0);
        send(16'h0003, 16'h0004, OP_MUL, 4'd5, 16'h000C, 5'b00010, 1'b0);
        chk("fill_level", level, 4);
        chk("fill_cmd_ready", cmd_ready, 0);
        cmd_a = 16'h0080; cmd_b = 16'h0000; cmd_fun = OP_SHR; cmd_tag = 4'd6; cmd_valid = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("full_hold_level", level, 4);
        chk("full_hold_ready", cmd_ready, 0);
        gap_from = cyc; gap_en = 1; rsp_ready = 1'b1;
        send(16'h0080, 16'h0000, OP_SHR, 4'd6, 16'h0040, 5'b10000, 1'b0);
        wait_drain();
        gap_en = 0;

        fun_bad = 0; fun_watch = 1;
        send(16'h0010, 16'h0000, OP_DIV, 4'd5, 16'hFFFF, 5'b00000, 1'b1);
        @(posedge clk); #1;
        chk("trap_valid_after_pop", rsp_valid, 1);
        wait_drain();
        fun_watch = 0;
        chk("trap_alu_fun_nop", fun_bad, 0);
        send(16'h0010, 16'h0004, OP_DIV, 4'd6, 16'h0004, 5'b00010, 1'b0);
        wait_drain();

        rsp_ready = 1'b0;
        send(16'h00F0, 16'h0FF0, OP_XOR, 4'd7, 16'h0F00, 5'b00100, 1'b0);
        send(16'h1200, 16'h0034, OP_OR,  4'd8, 16'h1234, 5'b00100, 1'b0);
        cnt = 0;
        while (!rsp_valid && cnt < 20) begin @(posedge clk); #1; cnt++; end
        chk("bp_valid", rsp_valid, 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_data", rsp_data, 16'h0F00);
            chk("bp_flags", rsp_flags, 5'b00100);
            chk("bp_tag", rsp_tag, 7);
            chk("bp_fun", ALU_FUN, OP_NOP);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_next_A", A, 16'h1200);
        chk("bp_next_B", B, 16'h0034);
        chk("bp_next_fun", ALU_FUN, OP_OR);
        wait_drain();

        send(16'h0100, 16'h00FF, OP_CMPGT, 4'd9, 16'h0002, 5'b01000, 1'b0);
        wait_drain();

        rsp_ready = 1'b0;
        send(16'h0001, 16'h0001, OP_ADD, 4'd10, 16'h0002, 5'b00010, 1'b0);
        send(16'h0002, 16'h0002, OP_ADD, 4'd11, 16'h0004, 5'b00010, 1'b0);
        send(16'h0003, 16'h0003, OP_ADD, 4'd12, 16'h0006, 5'b00010, 1'b0);
        chk("pre_rst_level", level, 2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_valid", rsp_valid, 0);
        chk("midrst_level", level, 0);
        chk("midrst_fun", ALU_FUN, OP_NOP);
        sb.delete();
        rst_n = 1'b1; rsp_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) cnt++;
        end
        chk("post_rst_no_rsp", cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
